// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad types, tracker states and the position-to-hex key map.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} tracker_state_t;

    typedef logic [3:0] keypos_t;

    // Nibble i holds the legend of position i = {row, col}; row 0 in the low nibbles.
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] keypos_to_hex(input keypos_t p);
        return KEYMAP[{p, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/stable_counter.sv
// stable_counter: saturating up-counter with synchronous clear and a terminal-value flag.
module stable_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         term
);

    logic [W-1:0] cnt_q, cnt_d;

    assign term = cnt_q == limit;

    always_comb cnt_d = clr ? '0 : (inc && !term) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/keypad_digit_tracker.sv
// keypad_digit_tracker: turns each stable keypad press into one event and a two-digit history.
module keypad_digit_tracker
    import keypad_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 50000,
    parameter int RELEASE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_pressed,
    input  logic [1:0] key_row,
    input  logic [1:0] key_col,
    output logic [3:0] new_digit,
    output logic [3:0] old_digit,
    output logic       key_event,
    output logic       key_held
);

    localparam int MAXC = (CONFIRM_CYCLES > RELEASE_CYCLES) ? CONFIRM_CYCLES : RELEASE_CYCLES;
    localparam int W    = $clog2(MAXC + 1);

    tracker_state_t state_q;
    keypos_t        pos_q;
    logic [3:0]     new_q, old_q;
    logic           event_q, held_q;
    keypos_t        pos;
    logic           same, run, term;
    logic [W-1:0]   limit;

    assign pos = {key_row, key_col};

    // The counter only runs on cycles that extend the current confirm or release window.
    always_comb begin
        same  = pos == pos_q;
        run   = (state_q == CONFIRM && key_pressed && same) || (state_q == RELEASE && !key_pressed);
        limit = (state_q == RELEASE) ? W'(RELEASE_CYCLES - 1) : W'(CONFIRM_CYCLES - 1);
    end

    stable_counter #(.W(W)) u_cnt (
        .clk  (clk),
        .rst_n(reset),
        .clr  (!run || term),
        .inc  (run),
        .limit(limit),
        .term (term)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            new_q   <= '0;
            old_q   <= '0;
            event_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            event_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (key_pressed) begin
                        state_q <= CONFIRM;
                        pos_q   <= pos;
                    end
                CONFIRM:
                    if (!key_pressed) state_q <= IDLE;
                    else if (!same) pos_q <= pos;
                    else if (term) begin
                        state_q <= HELD;
                        new_q   <= keypos_to_hex(pos_q);
                        old_q   <= new_q;
                        event_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                HELD:
                    if (!key_pressed) state_q <= RELEASE;
                RELEASE:
                    if (key_pressed) state_q <= HELD;
                    else if (term) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end
                default: state_q <= IDLE;
            endcase
        end

    assign new_digit = new_q;
    assign old_digit = old_q;
    assign key_event = event_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_digit_tracker.sv
// tb_keypad_digit_tracker: directed presses with a scoreboard of expected events checked by a monitor.
module tb_keypad_digit_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_pressed;
    logic [1:0] key_row, key_col;
    logic [3:0] new_digit, old_digit;
    logic       key_event, key_held;

    typedef struct {
        int         cyc;
        logic [3:0] nd;
        logic [3:0] od;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    keypad_digit_tracker #(.CONFIRM_CYCLES(4), .RELEASE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_pressed(key_pressed),
        .key_row    (key_row),
        .key_col    (key_col),
        .new_digit  (new_digit),
        .old_digit  (old_digit),
        .key_event  (key_event),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] nd, input logic [3:0] od);
        exp_t e;
        e.cyc = c;
        e.nd  = nd;
        e.od  = od;
        q.push_back(e);
    endtask

    task automatic step(input logic p, input logic [1:0] r, input logic [1:0] c, input int n, output int k);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) k = cyc;
            key_pressed = p;
            key_row     = r;
            key_col     = c;
        end
    endtask

    // Press that must confirm: the event lands 5 cycle counts after the driving negedge.
    task automatic press_ev(input logic [1:0] r, input logic [1:0] c, input int n,
                            input logic [3:0] nd, input logic [3:0] od);
        int k;
        step(1'b1, r, c, 1, k);
        push(k + 5, nd, od);
        if (n > 1) step(1'b1, r, c, n - 1, k);
    endtask

    always @(negedge clk)
        if (reset && key_event) begin
            exp_t e;
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_event: got event at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_new_digit", new_digit, e.nd);
                chk("event_old_digit", old_digit, e.od);
            end
        end

    initial begin
        int k;
        reset = 1'b0;
        key_pressed = 1'b0;
        key_row = 2'd0;
        key_col = 2'd0;
        @(negedge clk);
        chk("rst_new", new_digit, 4'h0);
        chk("rst_old", old_digit, 4'h0);
        chk("rst_event", key_event, 1'b0);
        chk("rst_held", key_held, 1'b0);
        reset = 1'b1;
        step(1'b0, 2'd0, 2'd0, 3, k);

        press_ev(2'd1, 2'd2, 20, 4'h6, 4'h0);
        chk("held_while_down", key_held, 1'b1);
        step(1'b0, 2'd0, 2'd0, 1, k);
        repeat (4) @(negedge clk);
        chk("held_before_idle", key_held, 1'b1);
        @(negedge clk);
        chk("held_after_idle", key_held, 1'b0);
        step(1'b0, 2'd0, 2'd0, 4, k);

        press_ev(2'd0, 2'd0, 8, 4'h1, 4'h6);
        step(1'b0, 2'd0, 2'd0, 8, k);
        press_ev(2'd3, 2'd1, 8, 4'h0, 4'h1);
        step(1'b0, 2'd0, 2'd0, 8, k);

        step(1'b1, 2'd2, 2'd2, 3, k);
        step(1'b0, 2'd0, 2'd0, 8, k);
        chk("short_new", new_digit, 4'h0);
        chk("short_old", old_digit, 4'h1);
        chk("short_held", key_held, 1'b0);

        press_ev(2'd1, 2'd1, 8, 4'h5, 4'h0);
        step(1'b1, 2'd2, 2'd3, 4, k);
        step(1'b0, 2'd2, 2'd3, 2, k);
        step(1'b1, 2'd2, 2'd3, 1, k);
        chk("bounce_held", key_held, 1'b1);
        step(1'b1, 2'd2, 2'd3, 3, k);
        chk("rollover_held", key_held, 1'b1);
        step(1'b0, 2'd0, 2'd0, 8, k);
        chk("rollover_new", new_digit, 4'h5);
        chk("rollover_old", old_digit, 4'h0);
        chk("rollover_released", key_held, 1'b0);

        step(1'b1, 2'd0, 2'd0, 2, k);
        press_ev(2'd0, 2'd3, 8, 4'hA, 4'h5);
        step(1'b0, 2'd0, 2'd0, 8, k);

        press_ev(2'd3, 2'd2, 8, 4'hF, 4'hA);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_new", new_digit, 4'h0);
        chk("midrst_old", old_digit, 4'h0);
        chk("midrst_event", key_event, 1'b0);
        chk("midrst_held", key_held, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(cyc + 5, 4'hF, 4'h0);
        step(1'b1, 2'd3, 2'd2, 8, k);
        step(1'b0, 2'd0, 2'd0, 8, k);

        repeat (10) @(negedge clk);
        chk("events_outstanding", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
